// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid geometry, coordinate widths and the
// food placer state encoding.
`default_nettype none

package snake_pkg;

   localparam int GRID_W = 40;
   localparam int GRID_H = 30;
   localparam int X_W    = 6;
   localparam int Y_W    = 5;
   localparam int RND_W  = 12;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAW   = 3'd1,
      S_SAMPLE = 3'd2,
      S_QUERY  = 3'd3,
      S_WAIT   = 3'd4,
      S_SCAN_Q = 3'd5,
      S_SCAN_W = 3'd6
   } state_e;

endpackage

`default_nettype wire

// File: rtl/food_placer_if.sv
// Food placer bundle: request, random source, occupancy query and result.
// The master side is the placer itself; the slave side is the game logic.
`default_nettype none

interface food_placer_if;

   logic                         req;
   logic                         rnd_en;
   logic [snake_pkg::RND_W-1:0]  rnd_data;
   logic                         occ_rd;
   logic [snake_pkg::X_W-1:0]    occ_x;
   logic [snake_pkg::Y_W-1:0]    occ_y;
   logic                         occ_hit;
   logic [snake_pkg::X_W-1:0]    food_x;
   logic [snake_pkg::Y_W-1:0]    food_y;
   logic                         food_valid;
   logic                         busy;
   logic                         grid_full;

   modport master (
      input  req, rnd_data, occ_hit,
      output rnd_en, occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, grid_full
   );

   modport slave (
      output req, rnd_data, occ_hit,
      input  rnd_en, occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, grid_full
   );

endinterface

`default_nettype wire

// File: rtl/food_placer.sv
// Picks a free grid cell for the next food item: random draws from an
// external LFSR first, then a raster scan when the draws keep failing.
`default_nettype none

module food_placer #(
   parameter int GRID_W    = snake_pkg::GRID_W,
   parameter int GRID_H    = snake_pkg::GRID_H,
   parameter int MAX_TRIES = 16
) (
   input  wire logic      clk,
   input  wire logic      rst,
   food_placer_if.master  fp_if
);

   import snake_pkg::*;

   localparam int                TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);
   localparam logic [X_W-1:0]    LAST_X   = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]    LAST_Y   = Y_W'(GRID_H - 1);

   state_e            state_q;
   logic [TRY_W-1:0]  try_q;
   logic [X_W-1:0]    scan_x_q;
   logic [Y_W-1:0]    scan_y_q;
   logic              rnd_en_q;
   logic              occ_rd_q;
   logic [X_W-1:0]    occ_x_q;
   logic [Y_W-1:0]    occ_y_q;
   logic [X_W-1:0]    food_x_q;
   logic [Y_W-1:0]    food_y_q;
   logic              food_valid_q;
   logic              grid_full_q;
   logic              busy_q;

   logic [X_W-1:0]    w_cand_x;
   logic [Y_W-1:0]    w_cand_y;
   logic              w_cand_ok;
   logic              w_tries_done;
   logic              w_scan_last_x;
   logic              w_scan_last_y;
   logic [X_W-1:0]    w_scan_nx;
   logic [Y_W-1:0]    w_scan_ny;
   logic              w_unused_msb;

   // The LFSR MSB is deliberately not part of the candidate coordinate.
   assign w_cand_x      = fp_if.rnd_data[X_W-1:0];
   assign w_cand_y      = fp_if.rnd_data[X_W+Y_W-1:X_W];
   assign w_unused_msb  = fp_if.rnd_data[RND_W-1];
   assign w_cand_ok     = (w_cand_x <= LAST_X) && (w_cand_y <= LAST_Y);
   assign w_tries_done  = (try_q == TRY_LAST);

   assign w_scan_last_x = (scan_x_q == LAST_X);
   assign w_scan_last_y = (scan_y_q == LAST_Y);
   assign w_scan_nx     = w_scan_last_x ? '0 : scan_x_q + X_W'(1);
   assign w_scan_ny     = w_scan_last_x ? scan_y_q + Y_W'(1) : scan_y_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         try_q        <= '0;
         scan_x_q     <= '0;
         scan_y_q     <= '0;
         rnd_en_q     <= 1'b0;
         occ_rd_q     <= 1'b0;
         occ_x_q      <= '0;
         occ_y_q      <= '0;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
         grid_full_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         // Strobes are raised on entry to DRAW/QUERY/SCAN_Q so they line up
         // with the state that owns them and never overlap.
         rnd_en_q <= 1'b0;
         occ_rd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fp_if.req) begin
                  state_q      <= S_DRAW;
                  rnd_en_q     <= 1'b1;
                  busy_q       <= 1'b1;
                  food_valid_q <= 1'b0;
                  grid_full_q  <= 1'b0;
                  try_q        <= '0;
               end
            end
            S_DRAW: begin
               state_q <= S_SAMPLE;
            end
            S_SAMPLE: begin
               if (w_cand_ok) begin
                  state_q  <= S_QUERY;
                  occ_rd_q <= 1'b1;
                  occ_x_q  <= w_cand_x;
                  occ_y_q  <= w_cand_y;
               end else if (w_tries_done) begin
                  state_q  <= S_SCAN_Q;
                  occ_rd_q <= 1'b1;
                  occ_x_q  <= '0;
                  occ_y_q  <= '0;
                  scan_x_q <= '0;
                  scan_y_q <= '0;
               end else begin
                  state_q  <= S_DRAW;
                  rnd_en_q <= 1'b1;
                  try_q    <= try_q + TRY_W'(1);
               end
            end
            S_QUERY: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (!fp_if.occ_hit) begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  food_x_q     <= occ_x_q;
                  food_y_q     <= occ_y_q;
                  food_valid_q <= 1'b1;
               end else if (w_tries_done) begin
                  state_q  <= S_SCAN_Q;
                  occ_rd_q <= 1'b1;
                  occ_x_q  <= '0;
                  occ_y_q  <= '0;
                  scan_x_q <= '0;
                  scan_y_q <= '0;
               end else begin
                  state_q  <= S_DRAW;
                  rnd_en_q <= 1'b1;
                  try_q    <= try_q + TRY_W'(1);
               end
            end
            S_SCAN_Q: begin
               state_q <= S_SCAN_W;
            end
            S_SCAN_W: begin
               if (!fp_if.occ_hit) begin
                  state_q      <= S_IDLE;
                  busy_q       <= 1'b0;
                  food_x_q     <= scan_x_q;
                  food_y_q     <= scan_y_q;
                  food_valid_q <= 1'b1;
               end else if (w_scan_last_x && w_scan_last_y) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  grid_full_q <= 1'b1;
               end else begin
                  state_q  <= S_SCAN_Q;
                  occ_rd_q <= 1'b1;
                  scan_x_q <= w_scan_nx;
                  scan_y_q <= w_scan_ny;
                  occ_x_q  <= w_scan_nx;
                  occ_y_q  <= w_scan_ny;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fp_if.rnd_en     = rnd_en_q;
   assign fp_if.occ_rd     = occ_rd_q;
   assign fp_if.occ_x      = occ_x_q;
   assign fp_if.occ_y      = occ_y_q;
   assign fp_if.food_x     = food_x_q;
   assign fp_if.food_y     = food_y_q;
   assign fp_if.food_valid = food_valid_q;
   assign fp_if.grid_full  = grid_full_q;
   assign fp_if.busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Parameter GRID_W, default 40, grid width in cells.
REQ-002 Parameter GRID_H, default 30, grid height in cells.
REQ-003 Parameter MAX_TRIES, default 16, random draws before falling back to linear scan.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  request a new food position; sampled only in IDLE.
REQ-007 rnd_en  output  1  enable to the external 12-bit LFSR generator; one-cycle pulse per draw.
REQ-008 rnd_data  input  12  LFSR state; holds the new value in the cycle after rnd_en.
REQ-009 occ_rd  output  1  occupancy query strobe, one cycle.
REQ-010 occ_x  output  6  queried column.
REQ-011 occ_y  output  5  queried row.
REQ-012 occ_hit  input  1  cell occupied by snake; valid exactly one cycle after occ_rd.
REQ-013 food_x  output  6  placed food column.
REQ-014 food_y  output  5  placed food row.
REQ-015 food_valid  output  1  food_x/food_y hold a valid free cell.
REQ-016 busy  output  1  placement in progress.
REQ-017 grid_full  output  1  no free cell exists; sticky until the next accepted req.

Function
REQ-018 FSM states SHALL be IDLE, DRAW, SAMPLE, QUERY, WAIT, SCAN_Q, SCAN_W, DONE-free (result loaded from WAIT/SCAN_W directly into IDLE).
REQ-019 IDLE: busy=0; req=1 -> DRAW, clear food_valid and grid_full, clear try counter; req=0 -> stay.
REQ-020 DRAW: rnd_en=1 for exactly one cycle -> SAMPLE.
REQ-021 SAMPLE: candidate x=rnd_data[5:0], y=rnd_data[10:6]; bit 11 ignored; if x>=GRID_W or y>=GRID_H, try counter +1 and -> DRAW (or SCAN_Q if count reaches MAX_TRIES); else -> QUERY.
REQ-022 QUERY: occ_rd=1, occ_x/occ_y=candidate -> WAIT.
REQ-023 WAIT: occ_hit=0 -> load food_x/food_y, food_valid=1 -> IDLE; occ_hit=1 -> try counter +1, -> DRAW, or SCAN_Q when count reaches MAX_TRIES.
REQ-024 Fast-path latency: food_valid SHALL rise on the 4th rising edge after the edge that accepted req.
REQ-025 SCAN_Q/SCAN_W: query cells in order x=0..GRID_W-1 within y=0..GRID_H-1, two cycles per cell; first free cell -> load food, food_valid=1 -> IDLE.
REQ-026 Scan past cell (GRID_W-1, GRID_H-1) with all hits -> grid_full=1, food_valid=0 -> IDLE.
REQ-027 req while busy=1 SHALL be ignored (not queued).
REQ-028 occ_rd and rnd_en SHALL never be asserted in the same cycle; occ_x/occ_y don't-care when occ_rd=0.
REQ-029 busy=1 in every state except IDLE.

Reset
REQ-030 rst=0 SHALL asynchronously force: state IDLE, food_x=0, food_y=0, food_valid=0, grid_full=0, busy=0, rnd_en=0, occ_rd=0, try counter=0, scan counters=0.
REQ-031 Reset mid-placement SHALL abandon the search; no partial result is output after reset release.

Structure
REQ-032 Shared package snake_pkg SHALL hold GRID_W, GRID_H, coordinate widths (6/5) and the FSM state enum.
REQ-033 No sub-module; the LFSR generator instance lives in the parent and connects via rnd_en/rnd_data.

Verification (LFSR taps 12'h053, reset seed 12'h001, shift right, feedback into MSB)
REQ-034 Reset, occ_hit=0, pulse req -> rnd_en once, rnd_data=12'h800, food (0,0), food_valid high 4 edges after req.
REQ-035 occ_hit=1 only for (0,0), pulse req -> second draw 12'h400, food (0,16), food_valid 8 edges after req.
REQ-036 MAX_TRIES=1, all cells occupied except (39,29) -> scan finds food (39,29), grid_full=0.
REQ-037 occ_hit tied 1, pulse req -> after MAX_TRIES draws and 1200 scanned cells: grid_full=1, food_valid=0, busy=0.
REQ-038 Pulse req during busy -> ignored, exactly one result; assert rst in WAIT -> all outputs reset values, IDLE next cycle.
